// File: rtl/cdc_sync_pkg.sv
// Shared types and helpers for the gray-pointer clock-domain synchroniser.
// The helpers take a runtime width so one definition serves every pointer size.
package cdc_sync_pkg;

  localparam int unsigned SR_LOCAL_MIN   = 2;
  localparam int unsigned SYNC_STAGE_MAX = 4;
  localparam int unsigned PTR_MAX_W      = 32;

  typedef enum logic [0:0] {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } cdc_sync_state_e;

  function automatic logic [PTR_MAX_W-1:0] width_mask(input int unsigned width);
    logic [PTR_MAX_W-1:0] mask;
    if (width >= PTR_MAX_W) begin
      mask = '1;
    end else begin
      mask = (PTR_MAX_W'(1) << width) - PTR_MAX_W'(1);
    end
    return mask;
  endfunction

  // Prefix-xor from the MSB down; bits above width are masked off first.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray,
                                                    input int unsigned width);
    logic [PTR_MAX_W-1:0] bin;
    bin = gray & width_mask(width);
    for (int s = 1; s < int'(PTR_MAX_W); s = s * 2) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

  // True when more than one bit differs, i.e. popcount(a ^ b) > 1.
  function automatic logic multi_bit_change(input logic [PTR_MAX_W-1:0] a,
                                            input logic [PTR_MAX_W-1:0] b,
                                            input int unsigned width);
    logic [PTR_MAX_W-1:0] diff;
    diff = (a ^ b) & width_mask(width);
    return (diff & (diff - PTR_MAX_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// Generic multi-flop synchroniser chain with async reset and synchronous clear.
// Exposes the last tap and the one before it so the caller can look one edge ahead.
module cdc_sync_chain #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             h_rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] tap_last,
  output logic [WIDTH-1:0] tap_prev
);

  // Element 0 is the first (metastability-catching) flop.
  logic [STAGES-1:0][WIDTH-1:0] s_q;

  always_ff @(posedge clk or negedge h_rst) begin
    if (!h_rst) begin
      s_q <= '0;
    end else if (clr) begin
      s_q <= '0;
    end else begin
      s_q <= {s_q[STAGES-2:0], d};
    end
  end

  assign tap_last = s_q[STAGES-1];
  assign tap_prev = s_q[STAGES-2];

endmodule

// File: rtl/ptr_cdc_sync.sv
// Gray pointer synchroniser: flop chain, registered binary view, advance strobe,
// flush/settle FSM and a sticky multi-bit-change error flag.
module ptr_cdc_sync
  import cdc_sync_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned SYNC_STAGE    = 2,
  parameter int unsigned SOFT_RESET    = 0
) (
  input  logic                   clk,
  input  logic                   h_rst,
  input  logic                   s_rst,
  input  logic [ADDRESS_WIDTH:0] gray_in,
  input  logic                   err_clr,
  output logic [ADDRESS_WIDTH:0] sync_gray,
  output logic [ADDRESS_WIDTH:0] sync_bin,
  output logic                   sync_valid,
  output logic                   ptr_adv,
  output logic [ADDRESS_WIDTH:0] ptr_delta,
  output logic                   gray_err
);

  localparam int unsigned PtrW   = ADDRESS_WIDTH + 1;
  localparam int unsigned CntW   = $clog2(SYNC_STAGE + 1);
  localparam bit          SoftEn = (SOFT_RESET >= SR_LOCAL_MIN) && (SOFT_RESET <= 3);

  if ((SYNC_STAGE < 2) || (SYNC_STAGE > SYNC_STAGE_MAX)) begin : g_bad_stage
    $error("ptr_cdc_sync: SYNC_STAGE must be in 2..%0d", SYNC_STAGE_MAX);
  end
  if (PtrW > PTR_MAX_W) begin : g_bad_width
    $error("ptr_cdc_sync: pointer wider than %0d bits", PTR_MAX_W);
  end

  logic            soft_clr;
  logic [PtrW-1:0] nxt;
  logic [PtrW-1:0] nxt_bin;
  logic            mbc;
  logic            flush_done;
  logic            adv_en;

  cdc_sync_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] sync_bin_q, sync_bin_d;
  logic            adv_q, adv_d;
  logic [PtrW-1:0] delta_q, delta_d;
  logic            err_q, err_d;

  assign soft_clr = SoftEn && s_rst;

  cdc_sync_chain #(
    .WIDTH  (PtrW),
    .STAGES (SYNC_STAGE)
  ) u_chain (
    .clk      (clk),
    .h_rst    (h_rst),
    .clr      (soft_clr),
    .d        (gray_in),
    .tap_last (sync_gray),
    .tap_prev (nxt)
  );

  assign nxt_bin    = PtrW'(gray2bin(PTR_MAX_W'(nxt), PtrW));
  assign mbc        = multi_bit_change(PTR_MAX_W'(nxt), PTR_MAX_W'(sync_gray), PtrW);
  assign flush_done = (state_q == FLUSH) && (cnt_q == CntW'(SYNC_STAGE - 1));
  // The settling edge already compares against the flushed value, so a pointer
  // that moved during FLUSH is reported together with sync_valid rising.
  assign adv_en     = (state_q == RUN) || flush_done;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_bin_d = nxt_bin;
    adv_d      = 1'b0;
    delta_d    = '0;
    err_d      = err_q;

    if (soft_clr) begin
      state_d    = FLUSH;
      cnt_d      = '0;
      sync_bin_d = '0;
    end else begin
      if (state_q == FLUSH) begin
        if (flush_done) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      if (adv_en) begin
        adv_d   = (nxt_bin != sync_bin_q);
        delta_d = nxt_bin - sync_bin_q;
      end

      if ((state_q == RUN) && mbc) begin
        err_d = 1'b1;
      end else if (err_clr) begin
        err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge h_rst) begin
    if (!h_rst) begin
      state_q    <= FLUSH;
      cnt_q      <= '0;
      sync_bin_q <= '0;
      adv_q      <= 1'b0;
      delta_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_bin_q <= sync_bin_d;
      adv_q      <= adv_d;
      delta_q    <= delta_d;
      err_q      <= err_d;
    end
  end

  assign sync_bin   = sync_bin_q;
  assign sync_valid = (state_q == RUN);
  assign ptr_adv    = adv_q;
  assign ptr_delta  = delta_q;
  assign gray_err   = err_q;

endmodule

// File: tb/tb_ptr_cdc_sync.sv
// Directed vector bench for ptr_cdc_sync (3-stage chain, 5-bit pointer) with a
// soft-reset-enabled instance and a soft-reset-ignoring instance on shared inputs.
module tb_ptr_cdc_sync;

  localparam int unsigned AW = 4;

  typedef struct packed {
    logic [AW:0] sg;
    logic [AW:0] sb;
    logic        valid;
    logic        adv;
    logic [AW:0] delta;
    logic        err;
  } obs_t;

  typedef struct {
    logic [AW:0] g;
    logic        clr;
    logic        srst;
    obs_t        exp;
    obs_t        exp0;
  } vec_t;

  logic        clk = 1'b0;
  logic        h_rst;
  logic        s_rst;
  logic        err_clr;
  logic [AW:0] gray_in;

  logic [AW:0] a_sg, a_sb, a_delta, b_sg, b_sb, b_delta;
  logic        a_valid, a_adv, a_err, b_valid, b_adv, b_err;
  obs_t        act_a, act_b;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ptr_cdc_sync #(
    .ADDRESS_WIDTH (AW),
    .SYNC_STAGE    (3),
    .SOFT_RESET    (2)
  ) dut (
    .clk        (clk),
    .h_rst      (h_rst),
    .s_rst      (s_rst),
    .gray_in    (gray_in),
    .err_clr    (err_clr),
    .sync_gray  (a_sg),
    .sync_bin   (a_sb),
    .sync_valid (a_valid),
    .ptr_adv    (a_adv),
    .ptr_delta  (a_delta),
    .gray_err   (a_err)
  );

  ptr_cdc_sync #(
    .ADDRESS_WIDTH (AW),
    .SYNC_STAGE    (3),
    .SOFT_RESET    (0)
  ) dut0 (
    .clk        (clk),
    .h_rst      (h_rst),
    .s_rst      (s_rst),
    .gray_in    (gray_in),
    .err_clr    (err_clr),
    .sync_gray  (b_sg),
    .sync_bin   (b_sb),
    .sync_valid (b_valid),
    .ptr_adv    (b_adv),
    .ptr_delta  (b_delta),
    .gray_err   (b_err)
  );

  assign act_a = {a_sg, a_sb, a_valid, a_adv, a_delta, a_err};
  assign act_b = {b_sg, b_sb, b_valid, b_adv, b_delta, b_err};

  function automatic obs_t mk(input int sg, input int sb, input int valid, input int adv,
                              input int delta, input int err);
    obs_t o;
    o.sg    = 5'(sg);
    o.sb    = 5'(sb);
    o.valid = 1'(valid);
    o.adv   = 1'(adv);
    o.delta = 5'(delta);
    o.err   = 1'(err);
    return o;
  endfunction

  task automatic add(input int g, input int clr, input int srst, input obs_t e, input obs_t e0);
    vec_t v;
    v.g    = 5'(g);
    v.clr  = 1'(clr);
    v.srst = 1'(srst);
    v.exp  = e;
    v.exp0 = e0;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t act, input obs_t exp);
    cmp({tag, " sync_gray"}, int'(act.sg), int'(exp.sg));
    cmp({tag, " sync_bin"}, int'(act.sb), int'(exp.sb));
    cmp({tag, " sync_valid"}, int'(act.valid), int'(exp.valid));
    cmp({tag, " ptr_adv"}, int'(act.adv), int'(exp.adv));
    cmp({tag, " ptr_delta"}, int'(act.delta), int'(exp.delta));
    cmp({tag, " gray_err"}, int'(act.err), int'(exp.err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    obs_t z, soft0, e;

    z     = mk(0, 0, 0, 0, 0, 0);
    soft0 = mk(13, 9, 1, 0, 0, 1);

    // Edge-by-edge table after h_rst release; SYNC_STAGE=3, so outputs after
    // edge e reflect gray_in applied before edge e-2.
    add(0,  0, 0, z, z);
    add(0,  0, 0, z, z);
    e = mk(0, 0, 1, 0, 0, 0);   add(0, 0, 0, e, e);
    add(1,  0, 0, e, e);
    add(1,  0, 0, e, e);
    e = mk(1, 1, 1, 1, 1, 0);   add(1, 0, 0, e, e);
    e = mk(1, 1, 1, 0, 0, 0);   add(1, 0, 0, e, e);
    add(19, 0, 0, e, e);
    add(17, 0, 0, e, e);
    e = mk(19, 29, 1, 1, 28, 1); add(16, 0, 0, e, e);
    e = mk(17, 30, 1, 1, 1, 1);  add(0,  0, 0, e, e);
    e = mk(16, 31, 1, 1, 1, 1);  add(1,  0, 0, e, e);
    e = mk(0, 0, 1, 1, 1, 1);    add(1,  0, 0, e, e);
    e = mk(1, 1, 1, 1, 1, 1);    add(1,  0, 0, e, e);
    e = mk(1, 1, 1, 0, 0, 0);    add(1,  1, 0, e, e);
    add(0,  0, 0, e, e);
    add(16, 0, 0, e, e);
    e = mk(0, 0, 1, 1, 31, 0);   add(1,  0, 0, e, e);
    e = mk(16, 31, 1, 1, 31, 0); add(1,  0, 0, e, e);
    e = mk(1, 1, 1, 1, 2, 1);    add(1,  1, 0, e, e);
    e = mk(1, 1, 1, 0, 0, 0);    add(1,  1, 0, e, e);
    add(13, 0, 0, e, e);
    add(13, 0, 0, e, e);
    e = mk(13, 9, 1, 1, 8, 1);   add(13, 0, 0, e, e);
    e = mk(13, 9, 1, 0, 0, 1);   add(13, 0, 0, e, e);
    e = mk(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(13, 0, 1, e, soft0);
    add(13, 0, 0, e, soft0);
    add(13, 0, 0, e, soft0);
    e = mk(13, 9, 1, 1, 9, 1);   add(13, 0, 0, e, soft0);
    add(13, 0, 0, soft0, soft0);
    e = mk(13, 9, 1, 0, 0, 0);   add(13, 1, 0, e, e);

    h_rst   = 1'b0;
    s_rst   = 1'b0;
    err_clr = 1'b0;
    gray_in = '0;
    tick();
    tick();
    check_obs("reset dut", act_a, z);
    check_obs("reset dut0", act_b, z);
    h_rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      gray_in = vecs[i].g;
      err_clr = vecs[i].clr;
      s_rst   = vecs[i].srst;
      tick();
      check_obs($sformatf("vec%0d dut", i + 1), act_a, vecs[i].exp);
      check_obs($sformatf("vec%0d dut0", i + 1), act_b, vecs[i].exp0);
    end
    err_clr = 1'b0;

    // Asynchronous h_rst between edges clears everything without a clock edge.
    #2;
    h_rst = 1'b0;
    #1;
    check_obs("async rst dut", act_a, z);
    check_obs("async rst dut0", act_b, z);
    tick();
    h_rst = 1'b1;

    // Pointer already non-zero through FLUSH: one pulse as sync_valid rises.
    tick();
    check_obs("flush e1", act_a, z);
    tick();
    check_obs("flush e2", act_a, z);
    tick();
    e = mk(13, 9, 1, 1, 9, 0);
    check_obs("flush e3 dut", act_a, e);
    check_obs("flush e3 dut0", act_b, e);
    tick();
    e = mk(13, 9, 1, 0, 0, 0);
    check_obs("flush e4", act_a, e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
